// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    // Canonical no-op (addi x0, x0, 0); handy as filler data when debugging.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        DISCARD
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {pc, instruction}, with flush and occupancy count.
// The head is read straight from the storage registers, so nothing entering on
// data_i can reach data_o in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PC_W + INST_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;
    logic             full;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign full    = (cnt_q == CNT_FULL);
    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = cnt_q;

    // Pointer and count update; flush wins over push/pop, pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_i, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; data only, no reset needed since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    // The fetch FSM reserves space before issuing, so a push into a full buffer is a bug.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(push_i && !flush_i && full));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding
// split address/data memory handshake, buffered {pc, instruction} queue and
// redirect-driven flush.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imemReq,
    output logic [PC_W-1:0]        imemAddr,
    input  logic                   imemGnt,
    input  logic                   imemRvalid,
    input  logic [INST_W-1:0]      imemRdata,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirectPc,
    output logic                   instValid,
    output logic [INST_W-1:0]      instruction,
    output logic [PC_W-1:0]        instPc,
    input  logic                   instReady,
    output logic [$clog2(DEPTH):0] queueCount
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [PC_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [PC_W-1:0]  ALIGN_MSK = 32'hFFFF_FFFC;

    fetch_state_t          state_q, state_d;
    logic [PC_W-1:0]       fetchPc_q, fetchPc_d;
    logic [PC_W-1:0]       reqPc_q, reqPc_d;
    logic [PC_W-1:0]       redirectTgt;
    logic                  push;
    logic                  pop;
    logic                  hasSpace;
    logic                  spaceAfterPush;
    logic [PC_W+INST_W-1:0] head;

    assign redirectTgt = redirectPc & ALIGN_MSK;
    // Redirect overrides consumption: the head being popped is flushed anyway.
    assign pop         = instValid && instReady && !redirect;
    // In IDLE nothing is outstanding, so occupancy alone decides.
    assign hasSpace    = (queueCount < CNT_FULL);
    // A push only happens below DEPTH, so either a concurrent pop or one free slot beyond it suffices.
    assign spaceAfterPush = pop || (queueCount < CNT_LAST);
    assign imemAddr    = fetchPc_q;

    // Next-state, request and push decisions; redirect retargets the fetch PC last.
    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        reqPc_d   = reqPc_q;
        imemReq   = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect || hasSpace) state_d = ADDR;
            end
            ADDR: begin
                imemReq = 1'b1;
                if (imemGnt) begin
                    state_d   = redirect ? DISCARD : WAIT;
                    reqPc_d   = fetchPc_q;
                    fetchPc_d = fetchPc_q + PC_STEP;
                end
            end
            WAIT: begin
                if (imemRvalid) begin
                    push    = !redirect;
                    state_d = (redirect || spaceAfterPush) ? ADDR : IDLE;
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (imemRvalid) state_d = ADDR;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) fetchPc_d = redirectTgt;
    end

    // Control state: FSM and fetch PC, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            fetchPc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
        end
    end

    // PC of the in-flight request, paired with its data on return.
    always_ff @(posedge clk) begin
        reqPc_q <= reqPc_d;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INST_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_i  ({reqPc_q, imemRdata}),
        .valid_o (instValid),
        .data_o  (head),
        .count_o (queueCount)
    );

    assign instPc      = head[PC_W+INST_W-1:INST_W];
    assign instruction = head[INST_W-1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed cycle-by-cycle bench for inst_fetch_queue.
module tb_inst_fetch_queue;
    import fetch_pkg::*;

    localparam int              DEPTH    = 4;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        instValid;
    logic [31:0] instruction;
    logic [31:0] instPc;
    logic        instReady = 1'b0;
    logic [2:0]  queueCount;

    int total = 0;
    int bad   = 0;
    int row_n = 0;

    typedef struct {
        logic [31:0] gnt, rv, rdata, rd, rpc, rdy;
        logic [31:0] e_req, e_addr, e_vld, e_inst, e_pc, e_cnt;
    } vec_t;

    vec_t tbl [26];

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemGnt     (imemGnt),
        .imemRvalid  (imemRvalid),
        .imemRdata   (imemRdata),
        .redirect    (redirect),
        .redirectPc  (redirectPc),
        .instValid   (instValid),
        .instruction (instruction),
        .instPc      (instPc),
        .instReady   (instReady),
        .queueCount  (queueCount)
    );

    always #5 clk = ~clk;

    function automatic vec_t V(input logic [31:0] gnt, rv, rdata, rd, rpc, rdy,
                               input logic [31:0] e_req, e_addr, e_vld, e_inst, e_pc, e_cnt);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row_n, act, exp);
        end
    endtask

    // Called at a falling edge: check state-driven outputs, drive inputs for the next rising edge.
    task automatic step(input vec_t v);
        chk("imemReq", 32'(imemReq), v.e_req);
        if (v.e_req[0]) chk("imemAddr", imemAddr, v.e_addr);
        chk("instValid", 32'(instValid), v.e_vld);
        chk("instruction", instruction, v.e_inst);
        chk("instPc", instPc, v.e_pc);
        chk("queueCount", 32'(queueCount), v.e_cnt);
        imemGnt    = v.gnt[0];
        imemRvalid = v.rv[0];
        imemRdata  = v.rdata;
        redirect   = v.rd[0];
        redirectPc = v.rpc;
        instReady  = v.rdy[0];
        @(negedge clk);
        row_n++;
    endtask

    initial begin
        // gnt rv rdata rd rpc rdy | req addr vld inst pc cnt
        // Sequential fetch 0x0, 0x4, 0x8 with immediate grant and 1-cycle data.
        tbl[0]  = V(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[1]  = V(1, 0, 0, 0, 0, 1,  1, 32'h0, 0, 0, 0, 0);
        tbl[2]  = V(0, 1, 32'h1000_0000, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[3]  = V(1, 0, 0, 0, 0, 1,  1, 32'h4, 1, 32'h1000_0000, 32'h0, 1);
        tbl[4]  = V(0, 1, 32'h1000_0004, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[5]  = V(1, 0, 0, 0, 0, 1,  1, 32'h8, 1, 32'h1000_0004, 32'h4, 1);
        tbl[6]  = V(0, 1, 32'h1000_0008, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[7]  = V(0, 0, 0, 0, 0, 1,  1, 32'hC, 1, 32'h1000_0008, 32'h8, 1);
        // Consumer stalls: queue fills to DEPTH and requests stop.
        tbl[8]  = V(1, 0, 0, 0, 0, 0,  1, 32'hC, 0, 0, 0, 0);
        tbl[9]  = V(0, 1, 32'h1000_000C, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[10] = V(1, 0, 0, 0, 0, 0,  1, 32'h10, 1, 32'h1000_000C, 32'hC, 1);
        tbl[11] = V(0, 1, 32'h1000_0010, 0, 0, 0,  0, 0, 1, 32'h1000_000C, 32'hC, 1);
        tbl[12] = V(1, 0, 0, 0, 0, 0,  1, 32'h14, 1, 32'h1000_000C, 32'hC, 2);
        tbl[13] = V(0, 1, 32'h1000_0014, 0, 0, 0,  0, 0, 1, 32'h1000_000C, 32'hC, 2);
        tbl[14] = V(1, 0, 0, 0, 0, 0,  1, 32'h18, 1, 32'h1000_000C, 32'hC, 3);
        tbl[15] = V(0, 1, 32'h1000_0018, 0, 0, 0,  0, 0, 1, 32'h1000_000C, 32'hC, 3);
        tbl[16] = V(0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h1000_000C, 32'hC, 4);
        tbl[17] = V(0, 0, 0, 0, 0, 1,  0, 0, 1, 32'h1000_000C, 32'hC, 4);
        tbl[18] = V(0, 0, 0, 0, 0, 0,  0, 0, 1, 32'h1000_0010, 32'h10, 3);
        tbl[19] = V(1, 0, 0, 0, 0, 0,  1, 32'h1C, 1, 32'h1000_0010, 32'h10, 3);
        // Redirect to 0x103 while waiting: flush, drop the returning word, refetch 0x100.
        tbl[20] = V(0, 0, 0, 1, 32'h103, 0,  0, 0, 1, 32'h1000_0010, 32'h10, 3);
        tbl[21] = V(0, 1, 32'h1000_001C, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[22] = V(1, 0, 0, 0, 0, 0,  1, 32'h100, 0, 0, 0, 0);
        tbl[23] = V(0, 1, 32'h1000_0100, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[24] = V(0, 0, 0, 0, 0, 1,  1, 32'h104, 1, 32'h1000_0100, 32'h100, 1);
        tbl[25] = V(0, 0, 0, 0, 0, 1,  1, 32'h104, 0, 0, 0, 0);

        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imemReq", 32'(imemReq), 32'h0);
        chk("rst_instValid", 32'(instValid), 32'h0);
        chk("rst_queueCount", 32'(queueCount), 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_instPc", instPc, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 26; i++) step(tbl[i]);

        // Redirect coincident with the grant: the granted word is discarded.
        step(V(1, 0, 0, 1, 32'h200, 0,  1, 32'h104, 0, 0, 0, 0));
        step(V(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        step(V(0, 1, NOP_INST, 0, 0, 0,  0, 0, 0, 0, 0, 0));

        // Grant withheld five cycles: request and address held steady.
        for (int i = 0; i < 5; i++) step(V(0, 0, 0, 0, 0, 0,  1, 32'h200, 0, 0, 0, 0));
        step(V(1, 0, 0, 0, 0, 0,  1, 32'h200, 0, 0, 0, 0));
        step(V(0, 1, 32'h2000_0200, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        step(V(0, 0, 0, 0, 0, 0,  1, 32'h204, 1, 32'h2000_0200, 32'h200, 1));

        // Redirect with rvalid, pop and push all in one cycle; target has low bits set and
        // sits at the top of the address space so the next fetch wraps to 0.
        step(V(1, 0, 0, 0, 0, 0,  1, 32'h204, 1, 32'h2000_0200, 32'h200, 1));
        step(V(0, 1, 32'h3333_3333, 1, 32'hFFFF_FFFF, 1,  0, 0, 1, 32'h2000_0200, 32'h200, 1));
        step(V(1, 0, 0, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, 0, 0, 0));
        step(V(0, 1, 32'h5555_AAAA, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        step(V(1, 0, 0, 0, 0, 0,  1, 32'h0, 1, 32'h5555_AAAA, 32'hFFFF_FFFC, 1));
        step(V(0, 1, 32'h1000_0000, 0, 0, 0,  0, 0, 1, 32'h5555_AAAA, 32'hFFFF_FFFC, 1));
        step(V(1, 0, 0, 0, 0, 0,  1, 32'h4, 1, 32'h5555_AAAA, 32'hFFFF_FFFC, 2));

        // Reset mid-WAIT with two entries: outputs clear before any clock edge.
        chk("pre_rst_count", 32'(queueCount), 32'h2);
        imemGnt = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_imemReq", 32'(imemReq), 32'h0);
        chk("async_instValid", 32'(instValid), 32'h0);
        chk("async_queueCount", 32'(queueCount), 32'h0);
        chk("async_instruction", instruction, 32'h0);
        chk("async_instPc", instPc, 32'h0);
        imemRvalid = 1'b1;
        imemRdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        reset = 1'b1;
        // Late rvalid arriving in IDLE right after release must be ignored.
        step(V(0, 1, 32'hBAD0_BAD0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        step(V(0, 0, 0, 0, 0, 0,  1, RESET_PC, 0, 0, 0, 0));
        step(V(0, 0, 0, 0, 0, 0,  1, RESET_PC, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle datapath and replaces its bare PC-to-instruction-memory path.
- Generates sequential fetch addresses and issues them to instruction memory over a split address/data handshake, with at most one request outstanding.
- Buffers returned words, each with its PC, in a small FIFO.
- Presents them to the datapath with a valid/ready handshake; a redirect (branch taken) flushes all buffered and in-flight work.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imemReq  out  1  address-phase request.
- imemAddr  out  32  fetch address, word aligned.
- imemGnt  in  1  address accepted this cycle (imemReq && imemGnt).
- imemRvalid  in  1  read data valid; arrives 1 or more cycles after the grant.
- imemRdata  in  32  instruction word.
- redirect  in  1  flush and restart fetch at redirectPc.
- redirectPc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- instValid  out  1  head entry valid.
- instruction  out  32  head instruction.
- instPc  out  32  head PC.
- instReady  in  1  datapath consumes the head this cycle.
- queueCount  out  $clog2(DEPTH)+1  number of buffered entries.

Behaviour:
Reset (async assert, sync release):
- fetchPc = RESET_PC, FIFO empty, state = IDLE.
- imemReq = 0, instValid = 0, queueCount = 0.
- instruction = 0, instPc = 0 while empty.

FSM states: IDLE, ADDR, WAIT, DISCARD.
- IDLE -> ADDR when the FIFO has space (queueCount + outstanding < DEPTH) and no redirect this cycle.
- ADDR:
  - imemReq = 1, imemAddr = fetchPc.
  - On imemGnt: go to WAIT; fetchPc += 4; capture reqPc.
  - imemReq stays high until granted. The address may change only because of a redirect; instruction memory tolerates this.
- WAIT:
  - On imemRvalid: push {reqPc, imemRdata}.
  - Next state is ADDR if space remains after the push; otherwise IDLE.
- DISCARD:
  - On imemRvalid: drop the data, no push.
  - Next state is ADDR; fetchPc is already the redirect target.

FIFO:
- Push and pop in the same cycle are both performed; count is unchanged.
- Pop occurs when instValid && instReady.
- Push when full cannot happen; the space check counts the outstanding request. An assertion must flag any violation.
- Head outputs are registered from storage (no combinational path from imemRdata); first-word latency is 1 cycle after rvalid.
- Pointers wrap modulo DEPTH.

Redirect (highest priority; overrides push and pop in the same cycle):
- FIFO flushed: count = 0, instValid = 0 next cycle.
- fetchPc = {redirectPc[31:2], 2'b00}.
- IDLE or ADDR without grant: go to ADDR with the new address next cycle.
- ADDR with imemGnt in the same cycle: go to DISCARD; fetchPc = redirect target.
- WAIT without rvalid: go to DISCARD.
- WAIT with imemRvalid in the same cycle: data dropped; go to ADDR.
- DISCARD: stay in DISCARD until rvalid.

Other rules:
- PC arithmetic is 32-bit and wraps 32'hFFFF_FFFC -> 0.
- Reset asserted mid-operation: immediate return to reset values. Any late imemRvalid after reset release while in IDLE is ignored.
- instReady while the FIFO is empty has no effect.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, ADDR, WAIT, DISCARD};
  - INST_W = 32 and PC_W = 32;
  - NOP_INST = 32'h0000_0013 (used by the bench and for debug).
- Sub-module fetch_fifo: synchronous DEPTH x 64-bit FIFO with push, pop, flush, count, and registered head.

Test Plan:
1. Reset release; memory grants immediately, rvalid 1 cycle later, instReady = 1 -> addresses 0x0, 0x4, 0x8 in order; instPc matches each; one outstanding request at a time.
2. instReady = 0 with a 4-entry queue -> exactly 4 words buffered, queueCount = 4, imemReq = 0. Asserting instReady for one cycle -> a new request is issued within 2 cycles.
3. redirect = 1, redirectPc = 0x103 while in WAIT -> the next rvalid is dropped, the next imemAddr is 0x100, and instValid = 0 until the 0x100 word arrives.
4. redirect in the same cycle as imemGnt for 0x8 -> DISCARD; the 0x8 data is never presented; the next request is to the redirect target.
5. Grant withheld for 5 cycles -> imemReq and imemAddr are held stable; on grant, a single entry is pushed.
6. Reset asserted while in WAIT with 2 entries buffered -> outputs return to reset values asynchronously; after release, the first imemAddr is RESET_PC.
